// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency memory requests and
// presents fetched words to decode through a 2-entry valid/ready buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] in_mem_addr,
    output logic        in_mem_en,
    input  logic [31:0] in_mem,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready
);

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_addr_q, inflight_addr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d;

    logic [31:0] target;
    logic [2:0]  occupancy;
    logic        pop;
    logic        push;
    logic        issue;
    logic        redirect_issue;
    logic        unused_target_lsbs;

    assign target             = {branch_target[31:2], 2'b00};
    assign unused_target_lsbs = ^branch_target[1:0];

    assign instr_valid = (count_q != 2'd0);
    assign instr_out   = head_instr_q;
    assign pc_out      = head_pc_q;

    always_comb begin
        pop       = instr_valid & instr_ready;
        push      = inflight_q & ~branch_taken;
        // Entries held or still owed after this edge; issue only if one slot stays free.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = ~reset & ~halt & (branch_taken | (occupancy < 3'd2));
        redirect_issue = ~reset & ~halt & branch_taken;
    end

    always_comb begin
        in_mem_en   = issue;
        in_mem_addr = redirect_issue ? target : pc_q;
    end

    // PC and in-flight tracking; a redirect overrides sequential advance.
    always_comb begin
        pc_d            = pc_q;
        inflight_d      = issue;
        inflight_addr_d = inflight_addr_q;
        if (branch_taken) begin
            if (!halt) begin
                pc_d            = target + 32'd4;
                inflight_addr_d = target;
            end else begin
                pc_d = target;
            end
        end else if (issue) begin
            pc_d            = pc_q + 32'd4;
            inflight_addr_d = pc_q;
        end
    end

    // Shift-style FIFO: the head registers drive the outputs directly.
    always_comb begin
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};

        case (count_q)
            2'd0: begin
                if (push) begin
                    head_instr_d = in_mem;
                    head_pc_d    = inflight_addr_q;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_instr_d = in_mem;
                    head_pc_d    = inflight_addr_q;
                end else if (push) begin
                    tail_instr_d = in_mem;
                    tail_pc_d    = inflight_addr_q;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_instr_d = tail_instr_q;
                    head_pc_d    = tail_pc_q;
                    if (push) begin
                        tail_instr_d = in_mem;
                        tail_pc_d    = inflight_addr_q;
                    end
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase

        if (branch_taken) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= 32'h0;
            count_q         <= 2'd0;
            head_instr_q    <= 32'h0;
            head_pc_q       <= 32'h0;
            tail_instr_q    <= 32'h0;
            tail_pc_q       <= 32'h0;
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            count_q         <= count_d;
            head_instr_q    <= head_instr_d;
            head_pc_q       <= head_pc_d;
            tail_instr_q    <= tail_instr_d;
            tail_pc_q       <= tail_pc_d;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_q == 2'd2)));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory returns addr ^ KEY, delivered entries are
// compared against an expected-PC queue loaded whenever the bench starts a fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        instr_ready;
    logic [31:0] in_mem_addr, in_mem, instr_out, pc_out;
    logic        in_mem_en, instr_valid;
    logic [31:0] w_addr, w_mem, w_instr, w_pc;
    logic        w_en, w_valid;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] sb_exp;
    bit          sb_on = 1'b0;
    logic [31:0] next_req;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
        .clk(clk), .reset(reset), .in_mem_addr(in_mem_addr), .in_mem_en(in_mem_en),
        .in_mem(in_mem), .halt(halt), .branch_taken(branch_taken),
        .branch_target(branch_target), .instr_out(instr_out), .pc_out(pc_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset), .in_mem_addr(w_addr), .in_mem_en(w_en),
        .in_mem(w_mem), .halt(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0), .instr_out(w_instr), .pc_out(w_pc),
        .instr_valid(w_valid), .instr_ready(1'b1)
    );

    always @(posedge clk) begin
        in_mem <= in_mem_en ? (in_mem_addr ^ KEY) : 32'hBAD0_BAD0;
        w_mem  <= w_en ? (w_addr ^ KEY) : 32'hBAD0_BAD0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every completed handshake must match the next expected fetch address.
    always @(negedge clk) begin
        if (!reset && sb_on && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", 32'(instr_valid), 32'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                check_eq("sb_pc", pc_out, sb_exp);
                check_eq("sb_instr", instr_out, sb_exp ^ KEY);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_load(input logic [31:0] start);
        sb_q.delete();
        for (int i = 0; i < 32; i++) sb_q.push_back(start + 32'(i * 4));
    endtask

    task automatic expect_req(input string tag);
        check_eq({tag, "_en"}, 32'(in_mem_en), 32'd1);
        check_eq({tag, "_addr"}, in_mem_addr, next_req);
        next_req = next_req + 32'd4;
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, "_en"}, 32'(in_mem_en), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        halt = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        instr_ready = 1'b1;
        next_req = 32'h100;
        repeat (2) step();
        #1;
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_en", 32'(in_mem_en), 32'd0);
        check_eq("rst_addr", in_mem_addr, 32'h100);
        check_eq("rst_instr", instr_out, 32'h0);
        check_eq("rst_pc", pc_out, 32'h0);
        check_eq("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

        // Reset release and steady streaming
        step();
        reset = 1'b0;
        sb_load(32'h100);
        sb_on = 1'b1;
        #1;
        expect_req("c0");
        step(); #1;
        expect_req("c1");
        check_eq("lat_c1_valid", 32'(instr_valid), 32'd0);
        step(); #1;
        check_eq("lat_c2_valid", 32'(instr_valid), 32'd1);
        expect_req("c2");
        check_eq("wrap_v0", 32'(w_valid), 32'd1);
        check_eq("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        check_eq("wrap_i0", w_instr, 32'hFFFF_FFF8 ^ KEY);
        step(); #1;
        expect_req("c3");
        check_eq("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        step(); #1;
        expect_req("c4");
        check_eq("wrap_pc2", w_pc, 32'h0000_0000);
        check_eq("wrap_i2", w_instr, 32'h0000_0000 ^ KEY);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            expect_req("flow");
            check_eq("flow_valid", 32'(instr_valid), 32'd1);
        end

        // Backpressure: buffer fills, requests stop, head holds
        step();
        instr_ready = 1'b0;
        #1;
        expect_idle("bp0");
        check_eq("bp0_pc", pc_out, sb_q[0]);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            expect_idle("bp");
            check_eq("bp_valid", 32'(instr_valid), 32'd1);
            check_eq("bp_hold_pc", pc_out, sb_q[0]);
            check_eq("bp_hold_instr", instr_out, sb_q[0] ^ KEY);
        end
        step();
        instr_ready = 1'b1;
        #1;
        expect_req("rel");
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            expect_req("rel_flow");
        end

        // Redirect while the buffer is full
        step();
        instr_ready = 1'b0;
        #1;
        expect_idle("pre_br0");
        step(); #1;
        expect_idle("pre_br1");
        step();
        branch_taken = 1'b1;
        branch_target = 32'h0000_2002;
        #1;
        next_req = 32'h2000;
        expect_req("br_a");
        step();
        branch_taken = 1'b0;
        instr_ready = 1'b1;
        sb_load(32'h2000);
        #1;
        check_eq("br_a_no_stale", 32'(instr_valid), 32'd0);
        expect_req("br_a1");
        step(); #1;
        check_eq("br_a_valid", 32'(instr_valid), 32'd1);
        check_eq("br_a_pc", pc_out, 32'h2000);
        expect_req("br_a2");
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            expect_req("br_a_flow");
        end

        // Redirect while streaming with a handshake in the same cycle
        step();
        branch_taken = 1'b1;
        branch_target = 32'h0000_3000;
        #1;
        next_req = 32'h3000;
        expect_req("br_b");
        step();
        branch_taken = 1'b0;
        sb_load(32'h3000);
        #1;
        check_eq("br_b_no_stale", 32'(instr_valid), 32'd0);
        expect_req("br_b1");
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            expect_req("br_b_flow");
        end

        // Halt: in-flight response still delivered, no new requests
        step();
        halt = 1'b1;
        #1;
        expect_idle("halt0");
        step(); #1;
        expect_idle("halt1");
        check_eq("halt1_valid", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            expect_idle("halt_idle");
            check_eq("halt_drained", 32'(instr_valid), 32'd0);
        end
        step();
        halt = 1'b0;
        #1;
        expect_req("resume");
        step(); #1;
        expect_req("resume1");
        step(); #1;
        expect_req("resume2");
        check_eq("resume_valid", 32'(instr_valid), 32'd1);

        // Asynchronous reset between edges with a full buffer
        step();
        instr_ready = 1'b0;
        #1;
        expect_idle("pre_rst0");
        step(); #1;
        expect_idle("pre_rst1");
        #2;
        reset = 1'b1;
        #1;
        sb_on = 1'b0;
        sb_q.delete();
        check_eq("arst_valid", 32'(instr_valid), 32'd0);
        check_eq("arst_en", 32'(in_mem_en), 32'd0);
        check_eq("arst_addr", in_mem_addr, 32'h100);
        check_eq("arst_pc", pc_out, 32'h0);
        step();
        step();
        reset = 1'b0;
        instr_ready = 1'b1;
        sb_load(32'h100);
        sb_on = 1'b1;
        next_req = 32'h100;
        #1;
        expect_req("post_rst0");
        step(); #1;
        expect_req("post_rst1");
        step(); #1;
        check_eq("post_rst_valid", 32'(instr_valid), 32'd1);
        expect_req("post_rst2");
        step(); #1;
        expect_req("post_rst3");
        step(); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
